// File: rtl/antifurto_ctrl.sv
// antifurto_ctrl: vehicle anti-theft FSM with a reprogrammable interval table, countdown timer and status/siren drive.
// Build option SIREN_PULSE_EN: siren toggles on each 1 Hz strobe in SOUND instead of holding steady.
module antifurto_ctrl #(
  parameter int N_DOORS      = 4,
  parameter int TW           = 4,
  parameter int T_ARM_DEF    = 6,
  parameter int T_DRIVER_DEF = 8,
  parameter int T_PASS_DEF   = 15,
  parameter int T_ALARM_DEF  = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] door,
  input  logic               reprogram,
  input  logic [1:0]         time_sel,
  input  logic [TW-1:0]      time_value,
  input  logic               one_hz_enable,
  output logic               status,
  output logic               siren,
  output logic [2:0]         state,
  output logic [TW-1:0]      countdown
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    SOUND      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_DELAY  = 3'd6,
    ILLEGAL    = 3'd7
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [TW-1:0] cd_r, cd_nxt_s, load_val_s;
  logic [TW-1:0] t_arm_r, t_drv_r, t_pass_r, t_alarm_r;
  logic          status_r, status_nxt_s, siren_r, siren_nxt_s;
  logic          load_en_s, expired_s, any_door_s, entered_s, timed_nxt_s;

  // A zero interval would never expire meaningfully, so it is stored as one second.
  function automatic logic [TW-1:0] sat_interval(input logic [TW-1:0] v);
    if (v == '0) return TW'(1);
    else         return v;
  endfunction

  assign any_door_s = |door;
  assign expired_s  = (cd_r == '0) &&
                      ((state_r == TRIGGERED) || (state_r == SOUND) || (state_r == ARM_DELAY));

  // Next-state decode; priority is reprogram, ignition, doors, then timer expiry.
  always_comb begin
    state_nxt_s = state_r;
    load_en_s   = 1'b0;
    load_val_s  = '0;
    if (state_r == ILLEGAL) begin
      state_nxt_s = ARMED;
    end else if (reprogram) begin
      state_nxt_s = ARMED;
    end else if (ignition) begin
      state_nxt_s = DISARMED;
    end else begin
      case (state_r)
        ARMED: begin
          if (door[0]) begin
            state_nxt_s = TRIGGERED;
            load_en_s   = 1'b1;
            load_val_s  = t_drv_r;
          end else if (any_door_s) begin
            state_nxt_s = TRIGGERED;
            load_en_s   = 1'b1;
            load_val_s  = t_pass_r;
          end else begin
            state_nxt_s = ARMED;
          end
        end
        TRIGGERED: begin
          if (expired_s) begin
            state_nxt_s = SOUND;
            load_en_s   = 1'b1;
            load_val_s  = t_alarm_r;
          end else begin
            state_nxt_s = TRIGGERED;
          end
        end
        SOUND: begin
          if (expired_s && any_door_s) begin
            load_en_s  = 1'b1;
            load_val_s = t_alarm_r;
          end else if (expired_s) begin
            state_nxt_s = ARMED;
          end else begin
            state_nxt_s = SOUND;
          end
        end
        DISARMED:  state_nxt_s = WAIT_OPEN;
        WAIT_OPEN: state_nxt_s = door[0] ? WAIT_CLOSE : WAIT_OPEN;
        WAIT_CLOSE: begin
          if (!any_door_s) begin
            state_nxt_s = ARM_DELAY;
            load_en_s   = 1'b1;
            load_val_s  = t_arm_r;
          end else begin
            state_nxt_s = WAIT_CLOSE;
          end
        end
        ARM_DELAY: begin
          if (any_door_s)     state_nxt_s = WAIT_CLOSE;
          else if (expired_s) state_nxt_s = ARMED;
          else                state_nxt_s = ARM_DELAY;
        end
        default: state_nxt_s = ARMED;
      endcase
    end
  end

  // Timer and output decode for the state being entered.
  always_comb begin
    entered_s    = reprogram || (state_nxt_s != state_r);
    timed_nxt_s  = (state_nxt_s == TRIGGERED) || (state_nxt_s == SOUND) ||
                   (state_nxt_s == ARM_DELAY);
    cd_nxt_s     = cd_r;
    status_nxt_s = 1'b0;
    siren_nxt_s  = 1'b0;
    if (load_en_s)                         cd_nxt_s = load_val_s;
    else if (!timed_nxt_s)                 cd_nxt_s = '0;
    else if (one_hz_enable && cd_r != '0)  cd_nxt_s = cd_r - TW'(1);
    else                                   cd_nxt_s = cd_r;
    case (state_nxt_s)
      ARMED:     status_nxt_s = entered_s ? 1'b0 : (status_r ^ one_hz_enable);
      TRIGGERED: status_nxt_s = 1'b1;
      SOUND:     status_nxt_s = 1'b1;
      default:   status_nxt_s = 1'b0;
    endcase
    if (state_nxt_s == SOUND) begin
`ifdef SIREN_PULSE_EN
      siren_nxt_s = entered_s ? 1'b1 : (siren_r ^ one_hz_enable);
`else
      siren_nxt_s = 1'b1;
`endif
    end else begin
      siren_nxt_s = 1'b0;
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ARMED;
      cd_r     <= '0;
      status_r <= 1'b0;
      siren_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cd_r     <= cd_nxt_s;
      status_r <= status_nxt_s;
      siren_r  <= siren_nxt_s;
    end
  end

  // Interval table, rewritten one entry per reprogram strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t_arm_r   <= TW'(T_ARM_DEF);
      t_drv_r   <= TW'(T_DRIVER_DEF);
      t_pass_r  <= TW'(T_PASS_DEF);
      t_alarm_r <= TW'(T_ALARM_DEF);
    end else if (reprogram) begin
      case (time_sel)
        2'd0:    t_arm_r   <= sat_interval(time_value);
        2'd1:    t_drv_r   <= sat_interval(time_value);
        2'd2:    t_pass_r  <= sat_interval(time_value);
        default: t_alarm_r <= sat_interval(time_value);
      endcase
    end
  end

  assign state     = state_r;
  assign countdown = cd_r;
  assign status    = status_r;
  assign siren     = siren_r;

endmodule

// File: tb/tb_antifurto_ctrl.sv
// Self-checking bench for antifurto_ctrl: directed vector table from the test plan, async-reset sequence,
// then randomized stimulus compared against a rule-level reference model.
module tb_antifurto_ctrl;

  localparam int S_ARMED = 0, S_TRIG = 1, S_SOUND = 2, S_DIS = 3, S_WOPEN = 4, S_WCLOSE = 5, S_ADLY = 6;
`ifdef SIREN_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       ignition;
  logic [3:0] door;
  logic       reprogram;
  logic [1:0] time_sel;
  logic [3:0] time_value;
  logic       one_hz_enable;
  logic       status, siren;
  logic [2:0] state;
  logic [3:0] countdown;

  int checks = 0;
  int failures = 0;

  antifurto_ctrl dut (
    .clock(clock), .reset(reset), .ignition(ignition), .door(door),
    .reprogram(reprogram), .time_sel(time_sel), .time_value(time_value),
    .one_hz_enable(one_hz_enable), .status(status), .siren(siren),
    .state(state), .countdown(countdown)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ign;
    logic [3:0] door;
    logic       rp;
    logic [1:0] sel;
    logic [3:0] val;
    logic       stb;
    int         st;
    int         cd;
    logic       status;
    logic       siren;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ign, input logic [3:0] d, input logic rp, input logic [1:0] sel,
                              input logic [3:0] val, input logic stb, input int st, input int cd,
                              input logic stat, input logic sir);
    vec_t v;
    v.ign = ign; v.door = d; v.rp = rp; v.sel = sel; v.val = val; v.stb = stb;
    v.st = st; v.cd = cd; v.status = stat; v.siren = sir;
    vecs.push_back(v);
  endfunction

  // Expected siren after k strobes spent in SOUND since entering it.
  function automatic logic sir_after(input int k);
    if (PULSE) return (k % 2) == 0;
    else       return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ign, input logic [3:0] d, input logic rp, input logic [1:0] sel,
                       input logic [3:0] val, input logic stb);
    ignition = ign; door = d; reprogram = rp; time_sel = sel; time_value = val; one_hz_enable = stb;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  int   m_state, m_cd;
  logic m_status, m_siren;
  int   m_tbl[4];

  function automatic bit is_timed(input int s);
    return (s == S_TRIG) || (s == S_SOUND) || (s == S_ADLY);
  endfunction

  function automatic void model_reset();
    m_state = S_ARMED; m_cd = 0; m_status = 1'b0; m_siren = 1'b0;
    m_tbl[0] = 6; m_tbl[1] = 8; m_tbl[2] = 15; m_tbl[3] = 10;
  endfunction

  function automatic void model_step(input logic ign, input logic [3:0] d, input logic rp,
                                     input int sel, input int val, input logic stb);
    int  ns, load;
    bit  expired, entered, open;
    open    = (d != 4'b0000);
    expired = is_timed(m_state) && (m_cd == 0);
    ns      = m_state;
    load    = -1;
    if (rp) begin
      m_tbl[sel] = (val == 0) ? 1 : val;
      m_state = S_ARMED; m_cd = 0; m_status = 1'b0; m_siren = 1'b0;
      return;
    end
    if (ign) ns = S_DIS;
    else if (m_state == S_ARMED && d[0]) begin ns = S_TRIG; load = m_tbl[1]; end
    else if (m_state == S_ARMED && open) begin ns = S_TRIG; load = m_tbl[2]; end
    else if (m_state == S_TRIG && expired) begin ns = S_SOUND; load = m_tbl[3]; end
    else if (m_state == S_SOUND && expired) begin
      if (open) load = m_tbl[3];
      else      ns = S_ARMED;
    end
    else if (m_state == S_DIS) ns = S_WOPEN;
    else if (m_state == S_WOPEN && d[0]) ns = S_WCLOSE;
    else if (m_state == S_WCLOSE && !open) begin ns = S_ADLY; load = m_tbl[0]; end
    else if (m_state == S_ADLY && open) ns = S_WCLOSE;
    else if (m_state == S_ADLY && expired) ns = S_ARMED;
    entered = (ns != m_state);
    if (load >= 0)                m_cd = load;
    else if (!is_timed(ns))       m_cd = 0;
    else if (stb && m_cd > 0)     m_cd = m_cd - 1;
    if (ns == S_ARMED)            m_status = entered ? 1'b0 : (m_status ^ stb);
    else                          m_status = (ns == S_TRIG) || (ns == S_SOUND);
    if (ns != S_SOUND)            m_siren = 1'b0;
    else if (!PULSE)              m_siren = 1'b1;
    else                          m_siren = entered ? 1'b1 : (m_siren ^ stb);
    m_state = ns;
  endfunction

  initial begin
    logic       r_ign, r_rp, r_stb;
    logic [3:0] r_door, r_val;
    logic [1:0] r_sel;

    // ---- directed vector table ----
    add(1'b0, 4'b0001, 1'b0, 2'd0, 4'd0, 1'b0, S_TRIG, 8, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_TRIG, i, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, S_SOUND, 10, 1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) add(1'b0, 4'b0100, 1'b0, 2'd0, 4'd0, 1'b1, S_SOUND, 10 - i, 1'b1, sir_after(i));
    add(1'b0, 4'b0100, 1'b0, 2'd0, 4'd0, 1'b0, S_SOUND, 10, 1'b1, sir_after(10));
    for (int i = 1; i <= 10; i++) add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_SOUND, 10 - i, 1'b1, sir_after(10 + i));
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, S_ARMED, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_ARMED, 0, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_ARMED, 0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, S_DIS, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, S_WOPEN, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0001, 1'b0, 2'd0, 4'd0, 1'b0, S_WCLOSE, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, S_ADLY, 6, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_ADLY, 6 - i, 1'b0, 1'b0);
    add(1'b0, 4'b0010, 1'b0, 2'd0, 4'd0, 1'b0, S_WCLOSE, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, S_ADLY, 6, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_ADLY, 6 - i, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, S_ARMED, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_ARMED, 0, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_ARMED, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 1'b0, 2'd0, 4'd0, 1'b0, S_TRIG, 15, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 2'd0, 4'd6, 1'b0, S_ARMED, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0011, 1'b0, 2'd0, 4'd0, 1'b0, S_TRIG, 8, 1'b1, 1'b0);
    add(1'b1, 4'b0001, 1'b1, 2'd1, 4'd0, 1'b1, S_ARMED, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, S_ARMED, 0, 1'b0, 1'b0);
    add(1'b0, 4'b0011, 1'b0, 2'd0, 4'd0, 1'b0, S_TRIG, 1, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_TRIG, 0, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, S_SOUND, 10, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, S_SOUND, 9, 1'b1, sir_after(1));

    // ---- reset state ----
    reset = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0);
    #12;
    check("reset.state", state, S_ARMED);
    check("reset.countdown", countdown, 0);
    check("reset.status", status, 1'b0);
    check("reset.siren", siren, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // ---- apply vector table ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ign, vecs[i].door, vecs[i].rp, vecs[i].sel, vecs[i].val, vecs[i].stb);
      tick();
      check($sformatf("vec%0d.state", i), state, vecs[i].st);
      check($sformatf("vec%0d.countdown", i), countdown, vecs[i].cd);
      check($sformatf("vec%0d.status", i), status, vecs[i].status);
      check($sformatf("vec%0d.siren", i), siren, vecs[i].siren);
    end
    drive(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0);

    // ---- asynchronous reset in the middle of SOUND ----
    #2;
    reset = 1'b0;
    #1;
    check("async_rst.state", state, S_ARMED);
    check("async_rst.countdown", countdown, 0);
    check("async_rst.siren", siren, 1'b0);
    check("async_rst.status", status, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 4'b0001, 1'b0, 2'd0, 4'd0, 1'b0);
    tick();
    check("after_rst.state", state, S_TRIG);
    check("after_rst.driver_interval", countdown, 8);
    drive(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0);

    // ---- randomized run against the reference model ----
    reset = 1'b0;
    #3;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    r_ign = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) r_ign = ~r_ign;
      r_door = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      r_rp   = ($urandom_range(0, 79) == 0);
      r_sel  = 2'($urandom);
      r_val  = 4'($urandom);
      r_stb  = ($urandom_range(0, 2) == 0);
      drive(r_ign, r_door, r_rp, r_sel, r_val, r_stb);
      tick();
      model_step(r_ign, r_door, r_rp, int'(r_sel), int'(r_val), r_stb);
      check($sformatf("rand%0d.state", c), state, m_state);
      check($sformatf("rand%0d.countdown", c), countdown, m_cd);
      check($sformatf("rand%0d.status", c), status, m_status);
      check($sformatf("rand%0d.siren", c), siren, m_siren);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
